// File: rtl/gps_bridge_pkg.sv
// Shared constants for the GPS sample to SPI bridge: shifter state codes,
// sample bit positions and frame sizing.
package gps_bridge_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam int BIT_I0 = 0;
  localparam int BIT_I1 = 1;
  localparam int BIT_Q0 = 2;
  localparam int BIT_Q1 = 3;

  function automatic int frame_bits(input int nbits, input int spf);
    return nbits * spf;
  endfunction

endpackage

// File: rtl/gps_frame_fifo.sv
// Show-ahead synchronous frame FIFO; a push into a full FIFO succeeds when a
// pop happens in the same cycle.
module gps_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gps_spi_packer.sv
// Packs GPS ADC samples into frames and streams them to an MCU as SPI mode 0
// with registered SCK/SS/MOSI; drops whole frames (sticky OVERRUN) when the FIFO is full.
module gps_spi_packer
  import gps_bridge_pkg::*;
#(
  parameter int NBITS             = 4,
  parameter int SAMPLES_PER_FRAME = 4,
  parameter int FIFO_DEPTH        = 2,
  parameter int SS_GAP_CYCLES     = 2
) (
  input  logic             MCU_CLK_25_000,
  input  logic             RESET_N,
  input  logic [NBITS-1:0] GPS_SAMPLE,
  input  logic             DATAREADY,
  output logic             MCU_SCK,
  output logic             MCU_SS,
  output logic             MCU_MOSI,
  output logic             OVERRUN,
  output logic             BUSY
);
  localparam int FB = frame_bits(NBITS, SAMPLES_PER_FRAME);
  localparam int CW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam int BW = (FB > 1) ? $clog2(FB) : 1;
  localparam int GW = (SS_GAP_CYCLES > 1) ? $clog2(SS_GAP_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [FB-1:0] asm_q, frame_d, fifo_dout, sreg;
  logic          push, pop, full, empty;
  logic [2:0]    state;
  logic [BW-1:0] bit_idx;
  logic [GW-1:0] gap_cnt;

  // Sample n lands at bits [n*NBITS +: NBITS] so the frame shifts out LSB first.
  always_comb begin
    frame_d = asm_q;
    frame_d[int'(cnt)*NBITS +: NBITS] = GPS_SAMPLE;
  end

  assign push = DATAREADY && (cnt == CW'(SAMPLES_PER_FRAME - 1));
  assign pop  = (state == ST_IDLE) && !empty;
  // LOAD covers the one cycle where the frame has left the FIFO but SS is not yet low.
  assign BUSY = !MCU_SS || !empty || (state == ST_LOAD);

  gps_frame_fifo #(.WIDTH(FB), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (MCU_CLK_25_000),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .din   (frame_d),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      cnt     <= '0;
      asm_q   <= '0;
      OVERRUN <= 1'b0;
    end else if (DATAREADY) begin
      asm_q <= frame_d;
      cnt   <= push ? '0 : cnt + 1'b1;
      if (push && full && !pop) OVERRUN <= 1'b1;
    end
  end

  // Pins are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      MCU_SCK  <= 1'b0;
      MCU_SS   <= 1'b1;
      MCU_MOSI <= 1'b0;
    end else begin
      MCU_SCK <= 1'b0;
      MCU_SS  <= 1'b0;
      case (state)
        ST_IDLE: begin
          MCU_SS   <= 1'b1;
          MCU_MOSI <= 1'b0;
          if (!empty) begin
            sreg    <= fifo_dout;
            bit_idx <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          MCU_MOSI <= sreg[0];
          state    <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          MCU_SCK <= 1'b1;
          if (bit_idx == BW'(FB - 1)) begin
            state <= ST_HOLD;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            sreg    <= sreg >> 1;
            state   <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          MCU_MOSI <= sreg[0];
          state    <= ST_SHIFT_HI;
        end
        ST_HOLD: begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          MCU_SS   <= 1'b1;
          MCU_MOSI <= 1'b0;
          if (gap_cnt == GW'(SS_GAP_CYCLES - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          MCU_SS   <= 1'b1;
          MCU_MOSI <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_spi_packer.sv
// Directed bench for gps_spi_packer: expected frames are queued as strobes are
// driven and compared against frames reassembled from the SPI pins.
module tb_gps_spi_packer;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] sample = '0;
  logic       dr = 1'b0;
  logic       sck, ss, mosi, ovr, busy;
  logic [1:0] sample1 = '0;
  logic       dr1 = 1'b0;
  logic       sck1, ss1, mosi1, ovr1, busy1;
  int         n_chk = 0, n_fail = 0;

  always #20 clk = ~clk;

  gps_spi_packer dut (
    .MCU_CLK_25_000(clk), .RESET_N(rst_n), .GPS_SAMPLE(sample), .DATAREADY(dr),
    .MCU_SCK(sck), .MCU_SS(ss), .MCU_MOSI(mosi), .OVERRUN(ovr), .BUSY(busy));

  gps_spi_packer #(.NBITS(2), .SAMPLES_PER_FRAME(1), .FIFO_DEPTH(2), .SS_GAP_CYCLES(1)) dut1 (
    .MCU_CLK_25_000(clk), .RESET_N(rst_n), .GPS_SAMPLE(sample1), .DATAREADY(dr1),
    .MCU_SCK(sck1), .MCU_SS(ss1), .MCU_MOSI(mosi1), .OVERRUN(ovr1), .BUSY(busy1));

  typedef struct {
    logic [15:0] data;
    int          nb;
    int          low;
    int          gap;
  } rx_t;

  rx_t         rxq[$];
  rx_t         rxq1[$];
  logic [15:0] expq[$];
  int          sck_rises = 0;

  // Reassemble frames from the pins: bit k = MOSI at the k-th SCK rise while SS is low.
  rx_t  cur, cur1;
  logic pss = 1'b1, psck = 1'b0, pss1 = 1'b1, psck1 = 1'b0;
  int   cyc = 0, last_rise = 0;

  always @(negedge clk) begin
    cyc++;
    if (sck === 1'b1 && psck === 1'b0) sck_rises++;
    if (ss === 1'b0) begin
      if (pss === 1'b1) begin
        cur.data = '0; cur.nb = 0; cur.low = 0; cur.gap = cyc - last_rise;
      end
      cur.low++;
      if (sck === 1'b1 && psck === 1'b0) begin
        if (cur.nb < 16) cur.data[cur.nb] = mosi;
        cur.nb++;
      end
    end else if (ss === 1'b1 && pss === 1'b0) begin
      rxq.push_back(cur);
      last_rise = cyc;
    end
    pss  = ss;
    psck = sck;
  end

  always @(negedge clk) begin
    if (ss1 === 1'b0) begin
      if (pss1 === 1'b1) begin
        cur1.data = '0; cur1.nb = 0; cur1.low = 0; cur1.gap = 0;
      end
      cur1.low++;
      if (sck1 === 1'b1 && psck1 === 1'b0) begin
        if (cur1.nb < 16) cur1.data[cur1.nb] = mosi1;
        cur1.nb++;
      end
    end else if (ss1 === 1'b1 && pss1 === 1'b0) begin
      rxq1.push_back(cur1);
    end
    pss1  = ss1;
    psck1 = sck1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_rx(input string tag, output rx_t r);
    int t = 0;
    while (rxq.size() == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, " frame_seen"}, int'(rxq.size() > 0), 1);
    if (rxq.size() > 0) r = rxq.pop_front();
    else r = '{data: '0, nb: 0, low: 0, gap: 0};
  endtask

  task automatic expect_frame(input string tag, output rx_t r);
    logic [15:0] e;
    get_rx(tag, r);
    e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
    check({tag, " data"}, int'(r.data), int'(e));
    check({tag, " bits"}, r.nb, 16);
    check({tag, " ss_low"}, r.low, 33);
  endtask

  // n strobes on consecutive cycles with values first, first+1, ...; the first
  // keep completed frames are expected on the wire.
  task automatic strobes(input int n, input int first, input int keep);
    logic [15:0] f = '0;
    logic [3:0]  v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v      = 4'(first + i);
      sample = v;
      dr     = 1'b1;
      f[4*(i%4) +: 4] = v;
      if (i % 4 == 3 && i / 4 < keep) expq.push_back(f);
    end
    @(negedge clk);
    dr = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] v);
    @(negedge clk);
    sample = v;
    dr     = 1'b1;
    @(negedge clk);
    dr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rx_t r;
    int  base, t;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst sck", int'(sck), 0);
    check("rst ss", int'(ss), 1);
    check("rst mosi", int'(mosi), 0);
    check("rst ovr", int'(ovr), 0);
    check("rst busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, LSB of oldest sample first
    strobe(4'h1); strobe(4'h2); strobe(4'h4); strobe(4'h8);
    expq.push_back(16'h8421);
    expect_frame("t1", r);
    repeat (5) @(negedge clk);

    // Back-to-back frames: SS high for the gap plus the IDLE pop cycle
    strobes(8, 3, 2);
    expect_frame("t2a", r);
    expect_frame("t2b", r);
    check("t2 ss_high", r.gap, 3);
    check("t2 ovr", int'(ovr), 0);
    repeat (5) @(negedge clk);

    // Overrun: fourth frame hits a full FIFO and is dropped
    strobes(16, 5, 3);
    expect_frame("t3a", r);
    expect_frame("t3b", r);
    expect_frame("t3c", r);
    repeat (80) @(negedge clk);
    check("t3 no_4th", rxq.size(), 0);
    check("t3 ovr", int'(ovr), 1);
    repeat (20) @(negedge clk);
    check("t3 ovr_sticky", int'(ovr), 1);
    pulse_reset();
    check("t3 ovr_cleared", int'(ovr), 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame after 8 bits
    base = sck_rises;
    strobes(4, 9, 0);
    t = 0;
    while (sck_rises < base + 8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t4 reached_bit7", int'(sck_rises >= base + 8), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4 ss", int'(ss), 1);
    check("t4 sck", int'(sck), 0);
    check("t4 busy", int'(busy), 0);
    base = sck_rises;
    repeat (80) @(negedge clk);
    check("t4 no_sck", sck_rises, base);
    get_rx("t4", r);
    check("t4 truncated_bits", r.nb, 8);

    // Partial frame stays put until its last sample arrives
    base = sck_rises;
    strobes(3, 1, 0);
    repeat (100) @(negedge clk);
    check("t5 no_sck", sck_rises, base);
    check("t5 ss", int'(ss), 1);
    check("t5 busy", int'(busy), 0);
    strobe(4'h4);
    expq.push_back(16'h4321);
    expect_frame("t5", r);

    // Two-bit, one-sample frames on the second instance
    @(negedge clk);
    sample1 = 2'b10;
    dr1     = 1'b1;
    @(negedge clk);
    dr1 = 1'b0;
    t = 0;
    while (rxq1.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6 frame_seen", int'(rxq1.size() > 0), 1);
    if (rxq1.size() > 0) begin
      r = rxq1.pop_front();
      check("t6 data", int'(r.data), 2);
      check("t6 bits", r.nb, 2);
      check("t6 ss_low", r.low, 5);
    end
    check("t6 ovr", int'(ovr1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
